// File: rtl/block_scan_counter_if.sv
// Control/position bundle for block_scan_counter.
// The master drives restart/go/mode; the slave (the counter) returns the scan position and flags.
interface block_scan_counter_if #(
  parameter int unsigned LOG2_N = 3
) ();

  localparam int unsigned IDX_W = 2 * LOG2_N;

  logic              restart;
  logic              go;
  logic [1:0]        mode;
  logic [LOG2_N-1:0] u;
  logic [LOG2_N-1:0] v;
  logic [IDX_W-1:0]  idx;
  logic              first;
  logic              last;
  logic              done;

  modport master (
    output restart, go, mode,
    input  u, v, idx, first, last, done
  );

  modport slave (
    input  restart, go, mode,
    output u, v, idx, first, last, done
  );

endinterface

// File: rtl/block_scan_counter.sv
// block_scan_counter: walks an N x N block (N = 2^LOG2_N) one position per go cycle.
// It emits the column u, the row v, the linear scan index and the first/last/done flags.
// Scan orders: raster, column-major and optional JPEG zigzag. Define BLOCK_SCAN_ZIGZAG_EN to
// include the zigzag order. Without it, mode 2 falls back to raster.
// CONTINUOUS=1 wraps to (0,0) after the last position and pulses done for one cycle.
module block_scan_counter #(
  parameter int unsigned LOG2_N     = 3,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  block_scan_counter_if.slave  bus
);

  localparam int unsigned W     = LOG2_N;
  localparam int unsigned IDX_W = 2 * LOG2_N;

  // N*N-1 is all ones in 2*LOG2_N bits.
  localparam logic [W-1:0]     POS_MAX = {W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

  localparam logic [1:0] MODE_COLUMN = 2'd1;
`ifdef BLOCK_SCAN_ZIGZAG_EN
  localparam logic [1:0] MODE_ZIGZAG = 2'd2;
`endif

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     u_q, u_d;
  logic [W-1:0]     v_q, v_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [1:0]       mode_q, mode_d;

  logic [W-1:0]     step_u;
  logic [W-1:0]     step_v;
  logic             last_c;

  assign last_c = (idx_q == IDX_MAX);

  // Compute the successor position for the latched scan order. It is only used when not at the last position.
  always_comb begin
    step_u = u_q;
    step_v = v_q;
    case (mode_q)
      MODE_COLUMN: begin
        if (v_q == POS_MAX) begin
          step_v = '0;
          step_u = u_q + W'(1);
        end else begin
          step_v = v_q + W'(1);
        end
      end
`ifdef BLOCK_SCAN_ZIGZAG_EN
      MODE_ZIGZAG: begin
        if ((u_q[0] ^ v_q[0]) == 1'b0) begin
          // Even diagonal: move up-right.
          if (u_q == POS_MAX) begin
            step_v = v_q + W'(1);
          end else if (v_q == '0) begin
            step_u = u_q + W'(1);
          end else begin
            step_u = u_q + W'(1);
            step_v = v_q - W'(1);
          end
        end else begin
          // Odd diagonal: move down-left.
          if (v_q == POS_MAX) begin
            step_u = u_q + W'(1);
          end else if (u_q == '0) begin
            step_v = v_q + W'(1);
          end else begin
            step_u = u_q - W'(1);
            step_v = v_q + W'(1);
          end
        end
      end
`endif
      default: begin
        // Raster. Mode 3 and any disabled mode also land here.
        if (u_q == POS_MAX) begin
          step_u = '0;
          step_v = v_q + W'(1);
        end else begin
          step_u = u_q + W'(1);
        end
      end
    endcase
  end

  // Next-state logic: restart has priority over go; DONE ignores go.
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    done_d  = CONTINUOUS ? 1'b0 : done_q;

    if (bus.restart) begin
      state_d = ST_RUN;
      u_d     = '0;
      v_d     = '0;
      idx_d   = '0;
      done_d  = 1'b0;
      mode_d  = bus.mode;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.go) begin
            if (last_c) begin
              done_d = 1'b1;
              if (CONTINUOUS) begin
                u_d   = '0;
                v_d   = '0;
                idx_d = '0;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              u_d   = step_u;
              v_d   = step_v;
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State and position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      u_q     <= '0;
      v_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      mode_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.u     = u_q;
  assign bus.v     = v_q;
  assign bus.idx   = idx_q;
  assign bus.done  = done_q;
  assign bus.first = (idx_q == '0);
  assign bus.last  = last_c;

endmodule
